instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Fetch stage that supplies the instruction word and PC to the decode/control path of the RISC-V core. It owns the PC register and issues word reads to a variable-latency instruction memory over a req/ack handshake. It presents Instr/PC/PCPlus4 with a valid/accept handshake to the downstream datapath. It consumes the PcSrc/PCTarget redirect produced by the control unit and ALU.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, PC loaded on reset
MAX_WAIT, 15, cycles allowed between imem_req assertion and imem_ack before bus timeout

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
imem_req  output  1  read request to instruction memory
imem_addr  output  XLEN  word address (byte address, [1:0]=0)
imem_ack  input  1  read data valid this cycle
imem_rdata  input  XLEN  instruction word
Instr  output  XLEN  held instruction for decode
PC  output  XLEN  address of Instr
PCPlus4  output  XLEN  PC + 4
instr_valid  output  1  Instr/PC valid
instr_accept  input  1  downstream consumes instruction this cycle
PcSrc  input  1  1 = take PCTarget; sampled only on accept
PCTarget  input  XLEN  branch/jump target
fetch_fault  output  1  sticky: misaligned target or bus timeout
fault_cause  output  2  01 misaligned, 10 timeout, 00 none

Behaviour:
- One clock domain. Reset is synchronous and active-high: clk and reset, fixed.
- FSM states: FETCH, HOLD, FAULT. Reset -> FETCH.
- Reset values: PC=RESET_PC, Instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, fetch_fault=0, fault_cause=0, wait counter=0.
- FETCH: imem_req=1, imem_addr=PC. imem_req drops to 0 in the first cycle after reset, then stays asserted until ack.
- FETCH with imem_ack=1: Instr<=imem_rdata, instr_valid<=1, go to HOLD, imem_req<=0. The minimum fetch latency is 1 cycle from req to the valid edge.
- Wait counter: increments each FETCH cycle without ack. When it reaches MAX_WAIT without ack: fault_cause=10, fetch_fault=1, go to FAULT.
- HOLD: Instr/PC held stable while instr_valid=1 and instr_accept=0.
- HOLD with instr_accept=1: next PC = PcSrc ? PCTarget : PCPlus4. Set instr_valid<=0, counter<=0, go to FETCH.
- Misaligned redirect: on accept with PcSrc=1 and PCTarget[1:0]!=0, PC is still loaded, fault_cause=01, fetch_fault=1, go to FAULT, and no request is issued.
- FAULT: imem_req=0, instr_valid=0, state held. Only reset exits.
- instr_accept while instr_valid=0 is ignored. PcSrc is don't-care unless accept&valid.
- imem_ack outside FETCH is ignored.
- PCPlus4 = PC + 4, modulo 2^XLEN. 32'hFFFF_FFFC wraps to 0 with no fault.
- Reset mid-fetch (req outstanding): state returns to FETCH at RESET_PC. Any ack in the reset cycle is dropped. Memory tolerates abandoned requests.
- Throughput: with 1-cycle ack and accept held high, one instruction every 2 cycles.

Decomposition:
- Shared package riscv_pkg: XLEN, RESET_PC, the NOP encoding 32'h0000_0013, the FSM state encoding (FETCH/HOLD/FAULT) and the fault_cause codes.
- One natural sub-module: pc_next_mux (combinational PcSrc select plus PCPlus4 adder), reusable by later pipelined variants.
- The FSM, wait counter and registers stay in instr_fetch_unit.

Test Plan:
- Reset then 1-cycle ack with rdata=32'h00500093, accept=1, PcSrc=0 -> Instr=32'h00500093 at PC=0, then PC=4 on the next fetch, imem_addr=4.
- Branch redirect: at PC=8, accept with PcSrc=1, PCTarget=32'h40 -> next imem_addr=32'h40, PCPlus4=32'h44.
- Backpressure: valid with accept=0 for 5 cycles -> Instr/PC unchanged, no new imem_req, and a single fetch after accept.
- Timeout: no ack for MAX_WAIT=15 cycles -> fetch_fault=1, fault_cause=10, imem_req=0 thereafter. Reset clears it and resumes at RESET_PC.
- Misaligned target: PCTarget=32'h42 with PcSrc=1 on accept -> fault_cause=01, no imem_req, instr_valid=0.
- Reset asserted while req outstanding and ack arrives the same cycle -> data discarded, instr_valid=0, next imem_addr=RESET_PC. Also PC=32'hFFFFFFFC with PcSrc=0 -> next PC=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: default widths, reset PC, NOP encoding,
// FSM state encoding and fault cause codes.
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          MAX_WAIT  = 15;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: sequential PC+4 or the redirect target chosen by PcSrc.
// Purely combinational so pipelined variants can reuse it.
module pc_next_mux
    import riscv_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [W-1:0] pc,
    input  logic         pc_src,
    input  logic [W-1:0] pc_target,
    output logic [W-1:0] pc_plus4,
    output logic [W-1:0] pc_next
);

    // PC+4 wraps modulo 2^W with no overflow handling.
    assign pc_plus4 = pc + W'(4);
    assign pc_next  = pc_src ? pc_target : pc_plus4;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction words over a req/ack bus and
// hands Instr/PC/PCPlus4 downstream with a valid/accept handshake.
//
// state | meaning
// FETCH | request outstanding at PC (req held low for the first cycle after reset)
// HOLD  | Instr/PC valid, waiting for downstream accept
// FAULT | misaligned redirect or bus timeout; only reset exits
module instr_fetch_unit #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
    parameter int              MAX_WAIT = riscv_pkg::MAX_WAIT
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            instr_valid,
    input  logic            instr_accept,
    input  logic            PcSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic            fetch_fault,
    output logic [1:0]      fault_cause
);
    import riscv_pkg::*;

    localparam int WW = $clog2(MAX_WAIT + 1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            req_q, req_d;
    logic            fault_q, fault_d;
    logic [1:0]      cause_q, cause_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [XLEN-1:0] pc_plus4, pc_next;

    pc_next_mux #(.W(XLEN)) u_pc_next (
        .pc        (pc_q),
        .pc_src    (PcSrc),
        .pc_target (PCTarget),
        .pc_plus4  (pc_plus4),
        .pc_next   (pc_next)
    );

    // Next-state and register updates for the fetch FSM.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        req_d   = req_q;
        fault_d = fault_q;
        cause_d = cause_q;
        wait_d  = wait_q;
        unique case (state_q)
            FETCH: begin
                req_d = 1'b1;
                // An ack only counts once the request is actually on the bus.
                if (req_q && imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    wait_d  = '0;
                    state_d = HOLD;
                end else if (req_q) begin
                    if (wait_q == WW'(MAX_WAIT - 1)) begin
                        fault_d = 1'b1;
                        cause_d = CAUSE_TIMEOUT;
                        req_d   = 1'b0;
                        state_d = FAULT;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (instr_accept) begin
                    pc_d    = pc_next;
                    valid_d = 1'b0;
                    wait_d  = '0;
                    // Misaligned target is still loaded into PC for debug visibility.
                    if (PcSrc && (PCTarget[1:0] != 2'b00)) begin
                        fault_d = 1'b1;
                        cause_d = CAUSE_MISALIGN;
                        req_d   = 1'b0;
                        state_d = FAULT;
                    end else begin
                        req_d   = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            FAULT: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
            default: state_d = FETCH;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR[XLEN-1:0];
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            fault_q <= 1'b0;
            cause_q <= CAUSE_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            wait_q  <= wait_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign Instr       = instr_q;
    assign PC          = pc_q;
    assign PCPlus4     = pc_plus4;
    assign instr_valid = valid_q;
    assign fetch_fault = fault_q;
    assign fault_cause = cause_q;

endmodule
